// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_pkg
//  Description : Shared widths, digit type and default wrap limits for the
//                MM:SS stopwatch core.
//  Revision    : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

    localparam int DIGIT_W    = 4;
    localparam int NUM_DIGITS = 4;

    // Default wrap points: seconds units, seconds tens, minutes units, minutes tens
    localparam int DEF_LIM0 = 9;
    localparam int DEF_LIM1 = 5;
    localparam int DEF_LIM2 = 9;
    localparam int DEF_LIM3 = 5;

    typedef logic [DIGIT_W-1:0]            digit_t;
    typedef logic [NUM_DIGITS*DIGIT_W-1:0] digit_vec_t;

    // True when a limit fits the 4-bit digit and allows at least two states
    function automatic bit lim_ok(input int lim);
        return (lim >= 1) && (lim <= 15);
    endfunction

endpackage : stopwatch_pkg
`default_nettype wire

// File: rtl/stopwatch_lim_digit.sv
`default_nettype none
// ============================================================================
//  Module      : lim_digit
//  Description : One 4-bit limited-increment digit. Adds the carry-in and
//                wraps to zero (raising carry-out) when the result would
//                exceed LIM. Synchronous clear has priority over counting.
//  Revision    : 1.0 - initial release
// ============================================================================
module lim_digit
    import stopwatch_pkg::*;
#(
    parameter int LIM = 9
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   clr,
    input  logic   ci,
    output digit_t q,
    output logic   co
);

    localparam logic [DIGIT_W:0] c_LIM = (DIGIT_W+1)'(LIM);

    digit_t           r_q_q;
    digit_t           w_q_d;
    logic [DIGIT_W:0] w_sum;

    // One extra bit so the compare sees the true sum even at 15 + 1
    assign w_sum = {1'b0, r_q_q} + {{DIGIT_W{1'b0}}, ci};
    assign co    = (w_sum > c_LIM);

    // Next value: clear wins, then wrap, else the incremented value
    always_comb begin
        w_q_d = w_sum[DIGIT_W-1:0];
        if (clr || co) begin
            w_q_d = '0;
        end
    end

    // Digit register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q_q <= '0;
        end else begin
            r_q_q <= w_q_d;
        end
    end

    assign q = r_q_q;

endmodule : lim_digit
`default_nettype wire

// File: rtl/stopwatch_counter.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_counter
//  Description : Four-digit MM:SS stopwatch. A chain of lim_digit instances
//                counts qualified ticks; the top keeps the run flag, the
//                one-cycle rollover pulse and, when STOPWATCH_LAP_EN is
//                defined, a lap-freeze shadow of the displayed digits.
//  Config      : `define STOPWATCH_LAP_EN to enable lap freeze; otherwise
//                the lap input is accepted and ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int LIM0 = DEF_LIM0,
    parameter int LIM1 = DEF_LIM1,
    parameter int LIM2 = DEF_LIM2,
    parameter int LIM3 = DEF_LIM3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic        start_stop,
    input  logic        clear,
    input  logic        lap,
    output logic [15:0] digits,
    output logic        running,
    output logic        rollover
);

    // Per-digit limits packed so the generate loop can pick its own slice
    localparam digit_vec_t c_LIM_VEC = {DIGIT_W'(LIM3), DIGIT_W'(LIM2),
                                        DIGIT_W'(LIM1), DIGIT_W'(LIM0)};

    logic [NUM_DIGITS:0]   w_carry;
    digit_vec_t            w_live;

    logic                  r_running_q;
    logic                  w_running_d;
    logic                  r_rollover_q;
    logic                  w_rollover_d;

    // A tick only counts if the watch was running before this edge
    assign w_carry[0] = tick & r_running_q;

    generate
        for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
            lim_digit #(
                .LIM (int'(c_LIM_VEC[g*DIGIT_W +: DIGIT_W]))
            ) u_digit (
                .clk   (clk),
                .rst_n (rst_n),
                .clr   (clear),
                .ci    (w_carry[g]),
                .q     (w_live[g*DIGIT_W +: DIGIT_W]),
                .co    (w_carry[g+1])
            );
        end
    endgenerate

    // Run toggle and wrap pulse; a clear on the wrap edge suppresses the pulse
    always_comb begin
        w_running_d  = r_running_q ^ start_stop;
        w_rollover_d = w_carry[NUM_DIGITS] & ~clear;
    end

    // Run flag and rollover pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_running_q  <= 1'b0;
            r_rollover_q <= 1'b0;
        end else begin
            r_running_q  <= w_running_d;
            r_rollover_q <= w_rollover_d;
        end
    end

    assign running  = r_running_q;
    assign rollover = r_rollover_q;

`ifdef STOPWATCH_LAP_EN
    logic       r_frozen_q;
    logic       w_frozen_d;
    digit_vec_t r_shadow_q;
    digit_vec_t w_shadow_d;

    // Lap toggles the freeze; entering freeze snapshots the pre-edge live count
    always_comb begin
        w_frozen_d = r_frozen_q;
        w_shadow_d = r_shadow_q;
        if (clear) begin
            w_frozen_d = 1'b0;
        end else if (lap) begin
            w_frozen_d = ~r_frozen_q;
            if (!r_frozen_q) begin
                w_shadow_d = w_live;
            end
        end
    end

    // Freeze flag and shadow registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frozen_q <= 1'b0;
            r_shadow_q <= '0;
        end else begin
            r_frozen_q <= w_frozen_d;
            r_shadow_q <= w_shadow_d;
        end
    end

    assign digits = r_frozen_q ? r_shadow_q : w_live;
`else
    logic w_unused_lap;

    // Lap has no function in this build
    assign w_unused_lap = lap;
    assign digits       = w_live;
`endif

endmodule : stopwatch_counter
`default_nettype wire
